cfg_dispatch: RTL and testbench
===============================

Name: cfg_dispatch

Overview:
Parametrised configuration dispatcher for the PE-array accelerator. It generalises the fixed four-channel cfg_valid/cfg_busy interface (data/wicp/tmpc/post) to NUM_CH channels. Commands are queued in a DEPTH-entry FIFO. Each command is issued to its masked channel engines, and the block waits for every addressed engine to report done before retiring it.

Parameters:
CWIDTH, 32, per-channel configuration word width
NUM_CH, 4, number of engine channels
DEPTH, 4, command FIFO depth (power of 2, ≥2)
CNT_W, 16, width of retired-command counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_valid  in  1  command offered
cfg_busy  out  1  command FIFO full; command not accepted this cycle
cfg_mask  in  NUM_CH  channels addressed by command
cfg_data  in  NUM_CH*CWIDTH  per-channel config words, channel i in bits [i*CWIDTH +: CWIDTH]
ch_start  out  NUM_CH  one-cycle start pulse per addressed channel
ch_cfg  out  NUM_CH*CWIDTH  config words presented to engines
ch_done  in  NUM_CH  one-cycle done pulse per channel
cmd_done  out  1  one-cycle pulse on command retirement
cmd_cnt  out  CNT_W  retired-command count
idle  out  1  FSM idle and FIFO empty

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values: cfg_busy=0, ch_start=0, ch_cfg=0, cmd_done=0, cmd_cnt=0, idle=1. FIFO pointers/count=0, pending=0, FSM=IDLE.
- Accept: a command is pushed when cfg_valid && !cfg_busy at a rising edge; {cfg_mask, cfg_data} is stored.
- cfg_busy is (fifo count == DEPTH). A push is refused in a full cycle even if a pop happens in the same cycle.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RETIRE.
- IDLE: if FIFO non-empty, pop the head at the edge. Latch the head mask into cur_mask and pending. Update ch_cfg slices where mask=1; slices with mask=0 hold. Go to ISSUE.
- ISSUE (1 cycle): ch_start = cur_mask. Next state is WAIT if the mask is non-zero, else RETIRE (no start is issued for mask 0).
- WAIT: each edge, pending <= pending & ~ch_done. When pending becomes 0, go to RETIRE.
  - ch_done on a non-pending channel is ignored.
  - ch_done during IDLE, ISSUE or RETIRE is ignored.
- RETIRE (1 cycle): cmd_done=1. cmd_cnt increments at the exiting edge and wraps from all-ones to 0. Go to IDLE.
- Latency: a command accepted at edge N is visible in the FIFO in cycle N+1, popped at edge N+1, and ch_start is high in cycle N+1 → N+2. Minimum command turnaround is 4 cycles (IDLE, ISSUE, WAIT, RETIRE). Minimum for a zero-mask command is 3 cycles.
- idle = (state==IDLE) && fifo empty.
- Commands retire strictly in acceptance order.
- rst mid-operation: flush FIFO, drop pending, return to IDLE, clear all outputs next cycle. No cmd_done is generated for flushed commands.

Optional Feature:
CFG_DISPATCH_TIMEOUT_EN
- Defined:
  - Adds parameter TO_CYCLES (default 1024) and output port timeout_err (1 bit).
  - A counter of width $clog2(TO_CYCLES+1) clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TO_CYCLES with pending≠0: pending forced to 0, FSM goes to RETIRE (cmd_done still pulses, cmd_cnt increments), and timeout_err sets.
  - timeout_err is sticky until rst.
- Undefined: no counter and no timeout_err port; WAIT lasts indefinitely.

Test Plan:
- Reset: hold rst 3 cycles mid-traffic → cfg_busy=0, ch_start=0, ch_cfg=0, cmd_done=0, cmd_cnt=0, idle=1 on the cycle after release.
- Single command: mask=4'b0101, data={32'hD,32'hC,32'hB,32'hA} accepted at edge N → ch_start=4'b0101 in cycle N+1..N+2, ch_cfg slices 0/2 = 32'hA/32'hC. Then ch_done[0] pulse, two cycles later ch_done[2] pulse → cmd_done one cycle after the ch_done[2] edge, cmd_cnt=1, idle=1 afterwards.
- Full FIFO: DEPTH=4, cfg_valid held high, no ch_done → exactly 5 commands accepted (1 in flight + 4 queued) and cfg_busy=1 thereafter. Completing the in-flight command → cfg_busy drops exactly once per retirement and the next command issues in order.
- Zero mask and stray done: mask=0 command → no ch_start, cmd_done 2 cycles after pop. ch_done[3] while only channel 1 is pending → still WAIT, until ch_done[1] arrives.
- Counter wrap: CNT_W=4, retire 17 zero-mask commands → cmd_cnt=1.
- With CFG_DISPATCH_TIMEOUT_EN, TO_CYCLES=8: mask=4'b0010, never assert ch_done → timeout_err=1 and cmd_done pulse after 8 WAIT cycles. The next command then completes normally, and timeout_err stays 1 until rst.

Source files
------------

// File: rtl/cfg_dispatch_if.sv
// Command and engine-side signal bundle for cfg_dispatch.
// master = command source / engine side, slave = the dispatcher.
interface cfg_dispatch_if #(
    parameter int CWIDTH = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic                     cfg_valid;
    logic                     cfg_busy;
    logic [NUM_CH-1:0]        cfg_mask;
    logic [NUM_CH*CWIDTH-1:0] cfg_data;
    logic [NUM_CH-1:0]        ch_start;
    logic [NUM_CH*CWIDTH-1:0] ch_cfg;
    logic [NUM_CH-1:0]        ch_done;
    logic                     cmd_done;
    logic [CNT_W-1:0]         cmd_cnt;
    logic                     idle;

    modport master (
        output cfg_valid, cfg_mask, cfg_data, ch_done,
        input  cfg_busy, ch_start, ch_cfg, cmd_done, cmd_cnt, idle
    );

    modport slave (
        input  cfg_valid, cfg_mask, cfg_data, ch_done,
        output cfg_busy, ch_start, ch_cfg, cmd_done, cmd_cnt, idle
    );
endinterface

// File: rtl/cfg_dispatch.sv
// NUM_CH-channel configuration dispatcher: FIFO-queued commands, issued to masked engines, retired in order.
// Optional WAIT watchdog enabled by defining CFG_DISPATCH_TIMEOUT_EN (adds TO_CYCLES and timeout_err).
module cfg_dispatch #(
    parameter int CWIDTH = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
`ifdef CFG_DISPATCH_TIMEOUT_EN
   ,parameter int TO_CYCLES = 1024
`endif
) (
    input  logic clk,
    input  logic rst,
    cfg_dispatch_if.slave bus
`ifdef CFG_DISPATCH_TIMEOUT_EN
   ,output logic timeout_err
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = NUM_CH * CWIDTH;
    localparam int EW = NUM_CH + DW;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [NUM_CH-1:0] cur_mask_q, cur_mask_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [DW-1:0]    ch_cfg_q, ch_cfg_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;

    logic              push, pop, fifo_full, fifo_empty;
    logic [NUM_CH-1:0] head_mask;
    logic [DW-1:0]     head_data;
    logic [NUM_CH-1:0] ch_start;
    logic              cmd_done;

`ifdef CFG_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    // Full blocks the push even when a pop happens in the same cycle.
    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.cfg_valid && !fifo_full;
    assign {head_mask, head_data} = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.cfg_mask, bus.cfg_data};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_mask_d = cur_mask_q;
        pending_d  = pending_q;
        ch_cfg_d   = ch_cfg_q;
        cmd_cnt_d  = cmd_cnt_q;
        pop        = 1'b0;
        ch_start   = '0;
        cmd_done   = 1'b0;
`ifdef CFG_DISPATCH_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cur_mask_d = head_mask;
                    pending_d  = head_mask;
                    // Unaddressed channels keep their previous configuration word.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (head_mask[i]) ch_cfg_d[i*CWIDTH +: CWIDTH] = head_data[i*CWIDTH +: CWIDTH];
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ch_start = cur_mask_q;
                state_d  = (|cur_mask_q) ? S_WAIT : S_RETIRE;
`ifdef CFG_DISPATCH_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                pending_d = pending_q & ~bus.ch_done;
`ifdef CFG_DISPATCH_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TW'(1);
                if (pending_d == '0) begin
                    state_d = S_RETIRE;
                end else if (to_cnt_q == TW'(TO_CYCLES - 1)) begin
                    pending_d     = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_RETIRE;
                end
`else
                if (pending_d == '0) state_d = S_RETIRE;
`endif
            end
            S_RETIRE: begin
                cmd_done  = 1'b1;
                cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_mask_q <= '0;
            pending_q  <= '0;
            ch_cfg_q   <= '0;
            cmd_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cur_mask_q <= cur_mask_d;
            pending_q  <= pending_d;
            ch_cfg_q   <= ch_cfg_d;
            cmd_cnt_q  <= cmd_cnt_d;
        end
    end

`ifdef CFG_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign bus.cfg_busy = fifo_full;
    assign bus.ch_start = ch_start;
    assign bus.ch_cfg   = ch_cfg_q;
    assign bus.cmd_done = cmd_done;
    assign bus.cmd_cnt  = cmd_cnt_q;
    assign bus.idle     = (state_q == S_IDLE) && fifo_empty;

endmodule

// File: tb/tb_cfg_dispatch.sv
// Directed bench for cfg_dispatch: reset, issue/wait/retire, FIFO full, zero mask, stray done, counter wrap.
// Built with CFG_DISPATCH_TIMEOUT_EN it also exercises the WAIT watchdog.
module tb_cfg_dispatch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    cfg_dispatch_if #(.CWIDTH(32), .NUM_CH(4), .CNT_W(4)) bus_if ();

`ifdef CFG_DISPATCH_TIMEOUT_EN
    logic timeout_err;
`endif

    cfg_dispatch #(
        .CWIDTH(32), .NUM_CH(4), .DEPTH(4), .CNT_W(4)
`ifdef CFG_DISPATCH_TIMEOUT_EN
       ,.TO_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
`ifdef CFG_DISPATCH_TIMEOUT_EN
       ,.timeout_err(timeout_err)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one command for exactly one edge; the FIFO is assumed not full.
    task automatic send(input logic [3:0] mask, input logic [127:0] data);
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_mask  = mask;
        bus_if.cfg_data  = data;
        tick(1);
        bus_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int t = 0;
        while (bus_if.ch_start == 4'b0 && t < 20) begin
            tick(1);
            t++;
        end
        chk(tag, (t < 20), 1'b1);
    endtask

    initial begin
        int  acc;
        int  pushes;
        int  dones;
        logic will;

        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_mask  = '0;
        bus_if.cfg_data  = '0;
        bus_if.ch_done   = '0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        chk("rst_busy",  bus_if.cfg_busy, 1'b0);
        chk("rst_start", bus_if.ch_start, 4'b0);
        chk("rst_cfg",   bus_if.ch_cfg,   128'h0);
        chk("rst_done",  bus_if.cmd_done, 1'b0);
        chk("rst_cnt",   bus_if.cmd_cnt,  4'd0);
        chk("rst_idle",  bus_if.idle,     1'b1);

        // Single command, mask 0101
        send(4'b0101, {32'hD, 32'hC, 32'hB, 32'hA});
        chk("single_queued_idle", bus_if.idle, 1'b0);
        chk("single_no_start_yet", bus_if.ch_start, 4'b0);
        tick(1);
        chk("single_start", bus_if.ch_start, 4'b0101);
        chk("single_cfg", bus_if.ch_cfg, {32'h0, 32'hC, 32'h0, 32'hA});
        tick(1);
        chk("single_start_pulse", bus_if.ch_start, 4'b0);
        bus_if.ch_done = 4'b0001;
        tick(1);
        bus_if.ch_done = 4'b0000;
        chk("single_partial_done", bus_if.cmd_done, 1'b0);
        tick(1);
        bus_if.ch_done = 4'b0100;
        tick(1);
        bus_if.ch_done = 4'b0000;
        chk("single_cmd_done", bus_if.cmd_done, 1'b1);
        chk("single_cnt_before", bus_if.cmd_cnt, 4'd0);
        tick(1);
        chk("single_done_pulse", bus_if.cmd_done, 1'b0);
        chk("single_cnt", bus_if.cmd_cnt, 4'd1);
        chk("single_idle", bus_if.idle, 1'b1);

        // Zero mask: no start, retire right after ISSUE, ch_cfg untouched
        send(4'b0000, {32'hFF, 32'hEE, 32'hDD, 32'hCC});
        tick(1);
        chk("zero_no_start", bus_if.ch_start, 4'b0);
        chk("zero_no_done_yet", bus_if.cmd_done, 1'b0);
        chk("zero_cfg_hold", bus_if.ch_cfg, {32'h0, 32'hC, 32'h0, 32'hA});
        tick(1);
        chk("zero_cmd_done", bus_if.cmd_done, 1'b1);
        tick(1);
        chk("zero_cnt", bus_if.cmd_cnt, 4'd2);

        // Done during ISSUE and on a non-pending channel are both ignored
        send(4'b0010, {32'h0, 32'h0, 32'h11, 32'h0});
        tick(1);
        chk("stray_start", bus_if.ch_start, 4'b0010);
        chk("stray_cfg", bus_if.ch_cfg, {32'h0, 32'hC, 32'h11, 32'hA});
        bus_if.ch_done = 4'b0010;
        tick(1);
        bus_if.ch_done = 4'b1000;
        tick(1);
        bus_if.ch_done = 4'b0000;
        chk("stray_still_wait", bus_if.cmd_done, 1'b0);
        tick(1);
        chk("stray_still_wait2", bus_if.cmd_done, 1'b0);
        chk("stray_not_idle", bus_if.idle, 1'b0);
        bus_if.ch_done = 4'b0010;
        tick(1);
        bus_if.ch_done = 4'b0000;
        chk("stray_cmd_done", bus_if.cmd_done, 1'b1);
        tick(1);
        chk("stray_cnt", bus_if.cmd_cnt, 4'd3);

        // FIFO full: valid held, nothing completes -> 1 in flight + 4 queued
        acc = 0;
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_mask  = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            bus_if.cfg_data = {96'h0, 32'h100 + acc};
            will = !bus_if.cfg_busy;
            tick(1);
            if (will) acc++;
        end
        chk("full_accepted", acc, 5);
        chk("full_busy", bus_if.cfg_busy, 1'b1);
        chk("full_inflight_cfg", bus_if.ch_cfg[31:0], 32'h100);
        bus_if.cfg_data = {96'h0, 32'h100 + acc};
        bus_if.ch_done = 4'b0001;
        tick(1);
        bus_if.ch_done = 4'b0000;
        chk("full_retire", bus_if.cmd_done, 1'b1);
        chk("full_busy_retire", bus_if.cfg_busy, 1'b1);
        tick(1);
        chk("full_busy_idle", bus_if.cfg_busy, 1'b1);
        tick(1);
        chk("full_busy_drop", bus_if.cfg_busy, 1'b0);
        chk("full_next_start", bus_if.ch_start, 4'b0001);
        chk("full_next_cfg", bus_if.ch_cfg[31:0], 32'h101);
        tick(1);
        acc++;
        bus_if.cfg_valid = 1'b0;
        chk("full_busy_again", bus_if.cfg_busy, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                wait_start("full_drain_start");
                chk("full_order", bus_if.ch_cfg[31:0], 32'h100 + k);
                tick(1);
            end
            bus_if.ch_done = 4'b0001;
            tick(1);
            bus_if.ch_done = 4'b0000;
            chk("full_drain_done", bus_if.cmd_done, 1'b1);
            tick(1);
        end
        chk("full_total_pushed", acc, 6);
        chk("full_cnt", bus_if.cmd_cnt, 4'd9);
        chk("full_idle", bus_if.idle, 1'b1);

        // Reset in the middle of traffic flushes everything without retiring
        send(4'b0100, {32'h0, 32'h77, 32'h0, 32'h0});
        send(4'b0100, {32'h0, 32'h78, 32'h0, 32'h0});
        tick(2);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("mid_rst_busy",  bus_if.cfg_busy, 1'b0);
        chk("mid_rst_start", bus_if.ch_start, 4'b0);
        chk("mid_rst_cfg",   bus_if.ch_cfg,   128'h0);
        chk("mid_rst_done",  bus_if.cmd_done, 1'b0);
        chk("mid_rst_cnt",   bus_if.cmd_cnt,  4'd0);
        chk("mid_rst_idle",  bus_if.idle,     1'b1);
        tick(3);
        chk("mid_rst_no_done", bus_if.cmd_done, 1'b0);
        chk("mid_rst_no_start", bus_if.ch_start, 4'b0);
        chk("mid_rst_still_idle", bus_if.idle, 1'b1);

        // 4-bit counter wraps after 16; 17 retirements leave 1
        pushes = 0;
        dones  = 0;
        bus_if.cfg_mask = 4'b0000;
        for (int c = 0; c < 300 && !(pushes == 17 && bus_if.idle); c++) begin
            bus_if.cfg_valid = (pushes < 17);
            will = bus_if.cfg_valid && !bus_if.cfg_busy;
            tick(1);
            if (will) pushes++;
            if (bus_if.cmd_done) dones++;
        end
        bus_if.cfg_valid = 1'b0;
        chk("wrap_dones", dones, 17);
        chk("wrap_cnt", bus_if.cmd_cnt, 4'd1);
        chk("wrap_idle", bus_if.idle, 1'b1);

`ifdef CFG_DISPATCH_TIMEOUT_EN
        // Watchdog: 8 WAIT cycles without done force retirement
        chk("to_err_clear", timeout_err, 1'b0);
        send(4'b0010, {32'h0, 32'h0, 32'h55, 32'h0});
        tick(1);
        chk("to_start", bus_if.ch_start, 4'b0010);
        tick(1);
        tick(7);
        chk("to_still_wait", bus_if.cmd_done, 1'b0);
        chk("to_err_not_yet", timeout_err, 1'b0);
        tick(1);
        chk("to_cmd_done", bus_if.cmd_done, 1'b1);
        chk("to_err_set", timeout_err, 1'b1);
        tick(1);
        chk("to_cnt", bus_if.cmd_cnt, 4'd2);
        send(4'b0001, {32'h0, 32'h0, 32'h0, 32'h66});
        tick(2);
        bus_if.ch_done = 4'b0001;
        tick(1);
        bus_if.ch_done = 4'b0000;
        chk("to_next_done", bus_if.cmd_done, 1'b1);
        chk("to_err_sticky", timeout_err, 1'b1);
        tick(1);
        chk("to_next_cnt", bus_if.cmd_cnt, 4'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("to_err_rst", timeout_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
